// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core's data-memory port. Accepts one
//   load/store at a time, waits WAIT_CYCLES cycles, performs the access on a
//   word-addressed, byte-strobed storage array and returns a response with an
//   error flag.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
//   are high. Request side: req_valid/req_ready. Response side:
//   rsp_valid/rsp_ready. rsp_valid never depends combinationally on rsp_ready,
//   and once raised it stays high with stable payload until accepted.
//
// Ports:
//   clk, rst         clock, synchronous active-low reset (also clears storage)
//   req_valid/ready  request handshake
//   req_write        1 = store, 0 = load
//   req_addr         byte address
//   req_wdata        store data
//   req_wstrb        byte enables for stores
//   rsp_valid/ready  response handshake
//   rsp_rdata        load data (0 for stores and errored requests)
//   rsp_err          misaligned or out-of-range request
//   dbg_state_o      current FSM state (0 IDLE, 1 WAIT, 2 RESP)
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state_o
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic        latch_en;
  logic        access_en;

  // With zero wait states the access happens on the acceptance edge itself,
  // so the operands come straight from the request port while idle and from
  // the latched copy otherwise.
  logic          acc_write;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_wstrb;
  logic          acc_err;
  logic [AW-1:0] acc_idx;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_en  = 1'b0;
    access_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          latch_en = 1'b1;
          cnt_d    = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            access_en = 1'b1;
            state_d   = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          access_en = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
    end
    acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIMIT);
    acc_idx = acc_addr[AW+1:2];
  end

  // Reset has priority, so a store still in WAIT never reaches storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (access_en) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_write) ? 32'd0 : mem_q[acc_idx];
        if (!acc_err && acc_write) begin
          for (int b = 0; b < 4; b++) begin
            if (acc_wstrb[b]) mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// 256 words, one instance with zero wait states for the back-to-back case.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;

  // Main instance (WAIT_CYCLES = 2)
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  // Zero-wait instance
  logic        req_valid_z, req_ready_z, req_write_z;
  logic [31:0] req_addr_z, req_wdata_z;
  logic [3:0]  req_wstrb_z;
  logic        rsp_valid_z, rsp_ready_z, rsp_err_z;
  logic [31:0] rsp_rdata_z;
  logic [1:0]  dbg_state_z;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state_o(dbg_state)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_wstrb(req_wstrb_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
    .rsp_err(rsp_err_z), .dbg_state_o(dbg_state_z)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one transaction on the main instance, starting #1 after an edge in
  // IDLE and returning #1 after the edge that completed the response.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble the request bus: the responder must use the latched copy.
    req_valid = 1'b0; req_write = ~wr; req_addr = a ^ 32'h4;
    req_wdata = ~wd; req_wstrb = ~ws;
    lat = 1;
    while (!rsp_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata_stable", rsp_rdata, rd);
      chk("bp_err_stable", 32'(rsp_err), 32'(er));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("req_ready_after_rsp", 32'(req_ready), 32'd1);
    chk("rsp_valid_after_rsp", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        zw  [4];
    logic [31:0] za  [4];
    logic [31:0] zd  [4];
    logic [3:0]  zs  [4];
    logic [31:0] zx  [4];
    int          k, got, last_acc;

    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b0;
    req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = '0; req_wdata_z = '0;
    req_wstrb_z = '0; rsp_ready_z = 1'b0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

    // Load from cleared storage
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld10_rdata", rd, 32'd0);
    chk("ld10_err", 32'(er), 32'd0);
    chk("ld10_lat", 32'(lat), 32'd3);

    // Full-word store then load
    do_req(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    chk("st40_lat", 32'(lat), 32'd3);
    chk("st40_err", 32'(er), 32'd0);
    chk("st40_rdata", rd, 32'd0);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld40_rdata", rd, 32'hDEADBEEF);
    chk("ld40_err", 32'(er), 32'd0);

    // Byte strobes: lanes 0 and 2 only
    do_req(1'b1, 32'h40, 32'h11223344, 4'b0101, 0, rd, er, lat);
    chk("st40b_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld40b_rdata", rd, 32'hDE22BE44);

    // Misaligned load within a populated word
    do_req(1'b0, 32'h42, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld42_err", 32'(er), 32'd1);
    chk("ld42_rdata", rd, 32'd0);

    // Out-of-range store aliasing word 0 must not write it
    do_req(1'b1, 32'h0, 32'h0BADC0DE, 4'hF, 0, rd, er, lat);
    chk("st0_err", 32'(er), 32'd0);
    do_req(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
    chk("st400_err", 32'(er), 32'd1);
    chk("st400_rdata", rd, 32'd0);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld0_rdata", rd, 32'h0BADC0DE);
    do_req(1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld_hi_err", 32'(er), 32'd1);

    // Last valid word
    do_req(1'b1, 32'h3FC, 32'h55AA55AA, 4'hF, 0, rd, er, lat);
    chk("st3fc_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld3fc_rdata", rd, 32'h55AA55AA);
    chk("ld3fc_err", 32'(er), 32'd0);

    // Store with no strobes leaves the word alone and is not an error
    do_req(1'b1, 32'h40, 32'h00000000, 4'h0, 0, rd, er, lat);
    chk("st40z_err", 32'(er), 32'd0);

    // Back-pressure for 5 cycles on a load
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 5, rd, er, lat);
    chk("bp_ld40_rdata", rd, 32'hDE22BE44);

    // Reset during the first WAIT cycle of a store
    req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_in_wait", 32'(dbg_state), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rsp_rdata", rsp_rdata, 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_req(1'b0, 32'h80, 32'h0, 4'h0, 0, rd, er, lat);
    chk("mid_ld80_rdata", rd, 32'd0);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat);
    chk("mid_ld40_cleared", rd, 32'd0);

    // Zero wait states: requests held continuously, accepted every 2 cycles
    zw[0] = 1'b1; za[0] = 32'h10; zd[0] = 32'h12345678; zs[0] = 4'hF;    zx[0] = 32'h0;
    zw[1] = 1'b0; za[1] = 32'h10; zd[1] = 32'h0;        zs[1] = 4'h0;    zx[1] = 32'h12345678;
    zw[2] = 1'b1; za[2] = 32'h14; zd[2] = 32'h9ABCDEF0; zs[2] = 4'b0011; zx[2] = 32'h0;
    zw[3] = 1'b0; za[3] = 32'h14; zd[3] = 32'h0;        zs[3] = 4'h0;    zx[3] = 32'h0000DEF0;
    k = 0; got = 0; last_acc = 0;
    rsp_ready_z = 1'b1;
    for (int n = 0; n < 30 && got < 4; n++) begin
      if (rsp_valid_z) begin
        chk("z_err", 32'(rsp_err_z), 32'd0);
        if (exp_q.size() > 0) chk("z_rdata", rsp_rdata_z, exp_q.pop_front());
        else chk("z_unexpected_rsp", 32'(rsp_valid_z), 32'd0);
        got++;
      end
      if (req_ready_z && k < 4) begin
        if (k > 0) chk("z_accept_gap", 32'(cyc - last_acc), 32'd2);
        last_acc = cyc;
        req_write_z = zw[k]; req_addr_z = za[k]; req_wdata_z = zd[k]; req_wstrb_z = zs[k];
        req_valid_z = 1'b1;
        exp_q.push_back(zx[k]);
        k++;
      end else if (k >= 4) begin
        req_valid_z = 1'b0;
      end
      @(posedge clk); #1;
    end
    req_valid_z = 1'b0;
    rsp_ready_z = 1'b0;
    chk("z_all_rsp", 32'(got), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port. It accepts one load/store request at a time over a valid/ready handshake and inserts a programmable number of wait states. It updates or reads a word-addressed, byte-strobed storage array and returns a response, with an error flag, over a second valid/ready handshake. It replaces the zero-latency data memory when the core is moved to a handshaked memory interface, and it doubles as the bench target for the core's load/store unit.

## Interface
Parameters:
- DEPTH_WORDS, 256: storage size in 32-bit words; power of two, 4 to 4096.
- WAIT_CYCLES, 2: wait states between request acceptance and response; 0 to 15.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte enables for stores; bit i selects bits [8i+7:8i]; ignored for loads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  32  load data; 0 for stores and errored loads.
- rsp_err  output  1  request was misaligned or out of range.

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid=1, latch write, addr, wdata, wstrb.
  - Load the wait counter with WAIT_CYCLES.
  - Go to WAIT, or straight to RESP if WAIT_CYCLES=0.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - On the edge where the counter equals 1, perform the access and go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready=1, return to IDLE.
- Access, performed once on the edge entering RESP:
  - err = (addr[1:0] != 0) or (addr >= 4*DEPTH_WORDS), with the comparison done on the full 32 bits.
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Store without err: write only the enabled byte lanes. wstrb=0 is legal: no change, err=0. rsp_rdata=0.
  - Load without err: rsp_rdata = full stored word.
  - Any err: storage is unchanged and rsp_rdata=0.
- Only one transaction is outstanding at a time. A new request is never accepted while in WAIT or RESP.
- Request inputs are sampled only at acceptance. Changes during WAIT or RESP are ignored.

## Timing
- Reset (rst=0 at an edge):
  - state=IDLE, counter=0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All storage words are cleared to 0 (synchronous clear).
- Reset asserted mid-transaction: the transaction is dropped. A store not yet committed (still in WAIT) never reaches storage. A store already committed (in RESP) stays written unless the clear overwrites it.
- Latency: a request accepted in cycle c has rsp_valid=1 starting in cycle c+1+WAIT_CYCLES.
- rsp_valid stays high until rsp_ready=1. Back-pressure of any length holds all response outputs constant.
- Response handshake in cycle r: req_ready=1 in cycle r+1.
- Minimum period between accepted requests is WAIT_CYCLES+2 cycles, or 2 cycles when WAIT_CYCLES=0.
- Read-after-write: a load accepted after a store's response returns the stored data.
- Outputs are registered or decoded from state only. There is no combinational path from req_* or rsp_ready to any output.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then rst=1 -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. A load of 0x0000_0010 returns 0.
- Store then load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF to 0x0000_0040 with wstrb=4'hF, accepted in cycle 10 -> rsp_valid in cycle 13, rsp_err=0, rsp_rdata=0.
  - Load of 0x40 -> 0xDEADBEEF.
- Byte strobes: after the word above, store 0x11223344 with wstrb=4'b0101 -> a load returns 0xDE22BE44.
- Errors:
  - Load of 0x0000_0042 -> rsp_err=1, rsp_rdata=0.
  - Store to 4*DEPTH_WORDS (0x400) -> rsp_err=1, and the load of word 0 is unchanged.
- Back-pressure and WAIT_CYCLES=0:
  - rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata are stable throughout, and req_ready=0.
  - With WAIT_CYCLES=0, back-to-back requests are accepted every 2 cycles.
- Mid-transaction reset: store 0xCAFEF00D to 0x80, then assert rst=0 in the first WAIT cycle -> after reset, rsp_valid=0, and a load of 0x80 returns 0.
